// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared CPU-side definitions for the SRAM arbiter.
//   - SRAM_ADDR_W : default SRAM address width (CPU addresses are zero-extended)
//   - CPU_DATA_W  : pipeline / SRAM data width
//   - arb_state_e : arbiter sequencer state encoding
//   - req_id_e    : requester identifiers (instruction fetch / MEM stage)
package mem_arbiter_pkg;

    localparam int unsigned SRAM_ADDR_W = 18;
    localparam int unsigned CPU_DATA_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_RD_DONE  = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5
    } arb_state_e;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: pipeline-side request/response bundle of the SRAM arbiter.
//   master modport : pipeline (drives fetch and data requests, receives data,
//                    completion pulses and the stall toward the hazard unit)
//   slave modport  : mem_arbiter
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                  if_req_i;
    logic [CPU_DATA_W-1:0] if_addr_i;
    logic [CPU_DATA_W-1:0] if_rdata_o;
    logic                  if_ready_o;
    logic                  mem_req_i;
    logic                  mem_we_i;
    logic [CPU_DATA_W-1:0] mem_addr_i;
    logic [CPU_DATA_W-1:0] mem_wdata_i;
    logic [CPU_DATA_W-1:0] mem_rdata_o;
    logic                  mem_ready_o;
    logic                  stall_o;

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
        input  if_rdata_o, if_ready_o, mem_rdata_o, mem_ready_o, stall_o
    );

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
        output if_rdata_o, if_ready_o, mem_rdata_o, mem_ready_o, stall_o
    );

endinterface

// File: rtl/mem_arbiter_fetch_buf.sv
// mem_arbiter_fetch_buf: one-entry fetch buffer (valid, tag, data) with hit compare.
//   CLK, RST        : clock, synchronous active-high reset (clears valid)
//   fill_en_i       : completed SRAM fetch; load tag/data and set valid
//   fill_tag_i/data : fetched address and word
//   inval_en_i      : a store is in its hold phase; clear valid on tag match
//   inval_addr_i    : store address
//   lookup_addr_i   : current fetch address
//   hit_o/hit_data_o: entry valid and tag equals lookup address, plus its data
module mem_arbiter_fetch_buf
    import mem_arbiter_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  fill_en_i,
    input  logic [CPU_DATA_W-1:0] fill_tag_i,
    input  logic [CPU_DATA_W-1:0] fill_data_i,
    input  logic                  inval_en_i,
    input  logic [CPU_DATA_W-1:0] inval_addr_i,
    input  logic [CPU_DATA_W-1:0] lookup_addr_i,
    output logic                  hit_o,
    output logic [CPU_DATA_W-1:0] hit_data_o
);

    logic                  valid_q, valid_d;
    logic [CPU_DATA_W-1:0] tag_q, tag_d;
    logic [CPU_DATA_W-1:0] data_q, data_d;

    // Entry update: refill wins; a store to the tagged address invalidates.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en_i) begin
            valid_d = 1'b1;
            tag_d   = fill_tag_i;
            data_d  = fill_data_i;
        end else if (inval_en_i && (inval_addr_i == tag_q)) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            tag_q   <= {CPU_DATA_W{1'b0}};
            data_q  <= {CPU_DATA_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_o      = valid_q && (tag_q == lookup_addr_i);
    assign hit_data_o = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the single-port 16-bit SRAM between instruction fetch
// and the MEM stage (strict MEM priority) and sequences the SRAM protocol.
//   Parameters : ADDR_W (SRAM address width), WE_PULSE (WE_n low cycles, 1..3)
//   CLK, RST   : clock, synchronous active-high reset
//   cpu        : pipeline-side requests/responses and stall_o (mem_arbiter_if.slave)
//   sram_*     : registered address/write data, bus drive enable, read data in,
//                active-low CE/OE/WE strobes
// Build option: define MEM_ARBITER_FETCH_BUF_EN to add a one-entry fetch buffer
// that answers repeated fetches without touching the SRAM.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = SRAM_ADDR_W,
    parameter int unsigned WE_PULSE = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    mem_arbiter_if.slave          cpu,
    output logic [ADDR_W-1:0]     sram_addr_o,
    output logic [CPU_DATA_W-1:0] sram_wdata_o,
    output logic                  sram_drive_o,
    input  logic [CPU_DATA_W-1:0] sram_rdata_i,
    output logic                  sram_ce_n_o,
    output logic                  sram_oe_n_o,
    output logic                  sram_we_n_o
);

    arb_state_e            state_q, state_d;
    req_id_e               gnt_id_q, gnt_id_d;
    logic [CPU_DATA_W-1:0] addr_q, addr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic                  drive_q, drive_d;
    logic                  if_ready_q, if_ready_d, mem_ready_q, mem_ready_d;
    logic [CPU_DATA_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
    logic [ADDR_W-1:0]     sram_addr_q, sram_addr_d;
    logic [CPU_DATA_W-1:0] sram_wdata_q, sram_wdata_d;

    logic                  if_pend_s, mem_pend_s, grant_s, buf_take_s;
    logic                  buf_hit_s;
    logic [CPU_DATA_W-1:0] buf_data_s;

    // A request whose ready is pulsing this cycle is finishing, not new.
    assign if_pend_s   = cpu.if_req_i  & ~if_ready_q;
    assign mem_pend_s  = cpu.mem_req_i & ~mem_ready_q;
    assign cpu.stall_o = (cpu.if_req_i & ~if_ready_q) | (cpu.mem_req_i & ~mem_ready_q);

`ifdef MEM_ARBITER_FETCH_BUF_EN
    mem_arbiter_fetch_buf u_fetch_buf (
        .CLK           (CLK),
        .RST           (RST),
        .fill_en_i     ((state_q == ST_RD) && (gnt_id_q == REQ_IF)),
        .fill_tag_i    (addr_q),
        .fill_data_i   (sram_rdata_i),
        .inval_en_i    (state_q == ST_WR_HOLD),
        .inval_addr_i  (addr_q),
        .lookup_addr_i (cpu.if_addr_i),
        .hit_o         (buf_hit_s),
        .hit_data_o    (buf_data_s)
    );
`else
    assign buf_hit_s  = 1'b0;
    assign buf_data_s = {CPU_DATA_W{1'b0}};
`endif

    // Next-state: arbitration in IDLE, then the fixed read/write sequences.
    always_comb begin
        state_d    = state_q;
        gnt_id_d   = gnt_id_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        grant_s    = 1'b0;
        buf_take_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_pend_s) begin
                    grant_s  = 1'b1;
                    gnt_id_d = REQ_MEM;
                    addr_d   = cpu.mem_addr_i;
                    state_d  = cpu.mem_we_i ? ST_WR_SETUP : ST_RD;
                end else if (if_pend_s) begin
                    if (buf_hit_s) begin
                        // Buffered fetch: answer next cycle, SRAM stays idle.
                        buf_take_s = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        grant_s  = 1'b1;
                        gnt_id_d = REQ_IF;
                        addr_d   = cpu.if_addr_i;
                        state_d  = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD:       state_d = ST_RD_DONE;
            ST_RD_DONE:  state_d = ST_IDLE;
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                cnt_d   = 2'(WE_PULSE - 1);
            end
            ST_WR_PULSE: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_WR_HOLD:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs: every strobe/ready is decoded from the next state and registered.
    always_comb begin
        ce_n_d       = 1'b1;
        oe_n_d       = 1'b1;
        we_n_d       = 1'b1;
        drive_d      = 1'b0;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if (grant_s) begin
            sram_addr_d = ADDR_W'(addr_d);
            if (gnt_id_d == REQ_MEM) begin
                sram_wdata_d = cpu.mem_wdata_i;
            end else begin
                sram_wdata_d = sram_wdata_q;
            end
        end else begin
            sram_addr_d = sram_addr_q;
        end
        case (state_d)
            ST_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            ST_RD_DONE: begin
                // Capture the bus at the end of RD for the granted requester.
                if (gnt_id_q == REQ_MEM) begin
                    mem_ready_d = 1'b1;
                    mem_rdata_d = sram_rdata_i;
                end else begin
                    if_ready_d = 1'b1;
                    if_rdata_d = sram_rdata_i;
                end
            end
            ST_WR_SETUP: begin
                ce_n_d  = 1'b0;
                drive_d = 1'b1;
            end
            ST_WR_PULSE: begin
                ce_n_d  = 1'b0;
                drive_d = 1'b1;
                we_n_d  = 1'b0;
            end
            ST_WR_HOLD: begin
                ce_n_d      = 1'b0;
                drive_d     = 1'b1;
                mem_ready_d = 1'b1;
            end
            ST_IDLE: begin
                if (buf_take_s) begin
                    if_ready_d = 1'b1;
                    if_rdata_d = buf_data_s;
                end else begin
                    if_ready_d = 1'b0;
                end
            end
            default: begin
                ce_n_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            gnt_id_q     <= REQ_IF;
            addr_q       <= {CPU_DATA_W{1'b0}};
            cnt_q        <= 2'd0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            drive_q      <= 1'b0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            if_rdata_q   <= {CPU_DATA_W{1'b0}};
            mem_rdata_q  <= {CPU_DATA_W{1'b0}};
            sram_addr_q  <= {ADDR_W{1'b0}};
            sram_wdata_q <= {CPU_DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            gnt_id_q     <= gnt_id_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            drive_q      <= drive_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign cpu.if_ready_o  = if_ready_q;
    assign cpu.if_rdata_o  = if_rdata_q;
    assign cpu.mem_ready_o = mem_ready_q;
    assign cpu.mem_rdata_o = mem_rdata_q;
    assign sram_addr_o     = sram_addr_q;
    assign sram_wdata_o    = sram_wdata_q;
    assign sram_drive_o    = drive_q;
    assign sram_ce_n_o     = ce_n_q;
    assign sram_oe_n_o     = oe_n_q;
    assign sram_we_n_o     = we_n_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter (WE_PULSE = 2) with a small
// SRAM model on the pin side.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic        sram_drive, sram_ce_n, sram_oe_n, sram_we_n;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] sram_mem [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_addr = 10'd0;
    logic [15:0] pre_data = 16'h0000;

    logic [7:0]  h_ce, h_oe, h_we, h_drv, h_ir, h_mr, h_st;
    logic [15:0] d_if, d_mem, d_wd;
    logic [17:0] a_rd;

    mem_arbiter_if bus ();

    mem_arbiter #(.ADDR_W(18), .WE_PULSE(2)) dut (
        .CLK          (clk),
        .RST          (rst),
        .cpu          (bus),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_drive_o (sram_drive),
        .sram_rdata_i (sram_rdata),
        .sram_ce_n_o  (sram_ce_n),
        .sram_oe_n_o  (sram_oe_n),
        .sram_we_n_o  (sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM model: combinational read, write on every clock WE_n is low.
    always @(posedge clk) begin
        if (pre_en) sram_mem[pre_addr] <= pre_data;
        else if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr[9:0]] <= sram_wdata;
    end
    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[9:0]] : 16'h0000;

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Runs n cycles from the current cycle 0, recording pins and dropping
    // each request once its ready is seen.
    task automatic run_cycles(input int n, input int drop_mem_at);
        h_ce = 8'hFF; h_oe = 8'hFF; h_we = 8'hFF; h_drv = 8'h00;
        h_ir = 8'h00; h_mr = 8'h00; h_st = 8'h00;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            h_ce[k] = sram_ce_n; h_oe[k] = sram_oe_n; h_we[k] = sram_we_n;
            h_drv[k] = sram_drive; h_ir[k] = bus.if_ready_o; h_mr[k] = bus.mem_ready_o;
            h_st[k] = bus.stall_o;
            if (k == 1) a_rd = sram_addr;
            if (k == 2) d_wd = sram_wdata;
            if (bus.if_ready_o) begin d_if = bus.if_rdata_o; bus.if_req_i = 1'b0; end
            if (bus.mem_ready_o) begin d_mem = bus.mem_rdata_o; bus.mem_req_i = 1'b0; end
            if (k == drop_mem_at) bus.mem_req_i = 1'b0;
        end
    endtask

    task automatic start_mem(input logic we, input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        bus.mem_req_i = 1'b1; bus.mem_we_i = we; bus.mem_addr_i = a; bus.mem_wdata_i = d;
    endtask

    task automatic test_reset_values;
        @(negedge clk);
        n_vec++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_drive} !== 4'b1110) begin
            n_err++; $display("FAIL reset_strobes got %b want 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_drive});
        end
        n_vec++;
        if ({bus.if_ready_o, bus.mem_ready_o, bus.if_rdata_o, bus.mem_rdata_o, sram_addr, sram_wdata} !== 68'd0) begin
            n_err++; $display("FAIL reset_regs got ir=%b mr=%b ird=%h mrd=%h a=%h wd=%h", bus.if_ready_o,
                bus.mem_ready_o, bus.if_rdata_o, bus.mem_rdata_o, sram_addr, sram_wdata);
        end
    endtask

    task automatic test_single_load;
        start_mem(1'b0, 16'h0040, 16'h0000);
        run_cycles(5, -1);
        n_vec++; if (h_mr[4:0] !== 5'b00100) begin n_err++; $display("FAIL load_ready got %b want 00100", h_mr[4:0]); end
        n_vec++; if (d_mem !== 16'hBEEF) begin n_err++; $display("FAIL load_data got %h want beef", d_mem); end
        n_vec++; if (h_st[4:0] !== 5'b00011) begin n_err++; $display("FAIL load_stall got %b want 00011", h_st[4:0]); end
        n_vec++; if (h_oe[4:0] !== 5'b11101) begin n_err++; $display("FAIL load_oe_n got %b want 11101", h_oe[4:0]); end
        n_vec++; if (a_rd !== 18'h00040) begin n_err++; $display("FAIL load_addr got %h want 00040", a_rd); end
    endtask

    task automatic test_store;
        start_mem(1'b1, 16'h0100, 16'h1234);
        run_cycles(7, -1);
        n_vec++; if (h_we[6:0] !== 7'b1110011) begin n_err++; $display("FAIL store_we_n got %b want 1110011", h_we[6:0]); end
        n_vec++; if (h_drv[6:0] !== 7'b0011110) begin n_err++; $display("FAIL store_drive got %b want 0011110", h_drv[6:0]); end
        n_vec++; if (h_mr[6:0] !== 7'b0010000) begin n_err++; $display("FAIL store_ready got %b want 0010000", h_mr[6:0]); end
        n_vec++; if (h_oe[6:0] !== 7'b1111111) begin n_err++; $display("FAIL store_oe_n got %b want 1111111", h_oe[6:0]); end
        n_vec++; if (d_wd !== 16'h1234) begin n_err++; $display("FAIL store_wdata got %h want 1234", d_wd); end
        n_vec++; if (sram_mem[10'h100] !== 16'h1234) begin n_err++; $display("FAIL store_mem got %h want 1234", sram_mem[10'h100]); end
    endtask

    task automatic test_if_mem_collision;
        @(posedge clk); #1;
        bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0010;
        bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 16'h0200;
        run_cycles(8, -1);
        n_vec++; if (h_mr !== 8'b00000100) begin n_err++; $display("FAIL coll_mem_ready got %b want 00000100", h_mr); end
        n_vec++; if (h_ir !== 8'b00100000) begin n_err++; $display("FAIL coll_if_ready got %b want 00100000", h_ir); end
        n_vec++; if (h_st !== 8'b00011111) begin n_err++; $display("FAIL coll_stall got %b want 00011111", h_st); end
        n_vec++; if (h_ce !== 8'b11101101) begin n_err++; $display("FAIL coll_ce_n got %b want 11101101", h_ce); end
        n_vec++; if ({d_mem, d_if} !== {16'h5A5A, 16'h0F0F}) begin
            n_err++; $display("FAIL coll_data got mem=%h if=%h want 5a5a 0f0f", d_mem, d_if);
        end
    endtask

    task automatic test_fetch_repeat;
        @(posedge clk); #1;
        bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0010;
        run_cycles(4, -1);
`ifdef MEM_ARBITER_FETCH_BUF_EN
        n_vec++; if (h_ir[3:0] !== 4'b0010) begin n_err++; $display("FAIL rep_if_ready got %b want 0010", h_ir[3:0]); end
        n_vec++; if (h_ce[3:0] !== 4'b1111) begin n_err++; $display("FAIL rep_ce_n got %b want 1111", h_ce[3:0]); end
`else
        n_vec++; if (h_ir[3:0] !== 4'b0100) begin n_err++; $display("FAIL rep_if_ready got %b want 0100", h_ir[3:0]); end
        n_vec++; if (h_ce[3:0] !== 4'b1101) begin n_err++; $display("FAIL rep_ce_n got %b want 1101", h_ce[3:0]); end
`endif
        n_vec++; if (d_if !== 16'h0F0F) begin n_err++; $display("FAIL rep_data got %h want 0f0f", d_if); end
        start_mem(1'b1, 16'h0010, 16'hCAFE);
        run_cycles(6, -1);
        @(posedge clk); #1;
        bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0010;
        run_cycles(4, -1);
        n_vec++; if (h_ir[3:0] !== 4'b0100) begin n_err++; $display("FAIL refetch_ready got %b want 0100", h_ir[3:0]); end
        n_vec++; if (h_ce[3:0] !== 4'b1101) begin n_err++; $display("FAIL refetch_ce_n got %b want 1101", h_ce[3:0]); end
        n_vec++; if (d_if !== 16'hCAFE) begin n_err++; $display("FAIL refetch_data got %h want cafe", d_if); end
    endtask

    task automatic test_back_to_back;
        start_mem(1'b0, 16'h0040, 16'h0000);
        h_mr = 8'h00; h_ce = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            h_mr[k] = bus.mem_ready_o; h_ce[k] = sram_ce_n;
            if (bus.mem_ready_o) begin
                d_mem = bus.mem_rdata_o;
                if (k == 2) bus.mem_addr_i = 16'h0080;
                else bus.mem_req_i = 1'b0;
            end
        end
        n_vec++; if (h_mr !== 8'b00100100) begin n_err++; $display("FAIL b2b_ready got %b want 00100100", h_mr); end
        n_vec++; if (h_ce !== 8'b11101101) begin n_err++; $display("FAIL b2b_ce_n got %b want 11101101", h_ce); end
        n_vec++; if (d_mem !== 16'h7777) begin n_err++; $display("FAIL b2b_data got %h want 7777", d_mem); end
    endtask

    task automatic test_withdraw;
        start_mem(1'b0, 16'h0080, 16'h0000);
        run_cycles(6, 1);
        n_vec++; if (h_mr[5:0] !== 6'b000100) begin n_err++; $display("FAIL wd_ready got %b want 000100", h_mr[5:0]); end
        n_vec++; if (h_ce[5:0] !== 6'b111101) begin n_err++; $display("FAIL wd_ce_n got %b want 111101", h_ce[5:0]); end
        n_vec++; if (h_st[5:0] !== 6'b000011) begin n_err++; $display("FAIL wd_stall got %b want 000011", h_st[5:0]); end
    endtask

    task automatic test_reset_mid_write;
        start_mem(1'b1, 16'h0300, 16'hAAAA);
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_vec++; if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL rstw_pre_we_n got %b want 0", sram_we_n); end
        rst = 1'b1; bus.mem_req_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({sram_we_n, sram_ce_n, sram_oe_n, sram_drive, bus.if_ready_o, bus.mem_ready_o, bus.stall_o} !== 7'b1110000) begin
            n_err++; $display("FAIL rstw_pins got %b want 1110000",
                {sram_we_n, sram_ce_n, sram_oe_n, sram_drive, bus.if_ready_o, bus.mem_ready_o, bus.stall_o});
        end
        n_vec++; if ({sram_addr, sram_wdata} !== 34'd0) begin n_err++; $display("FAIL rstw_regs got a=%h wd=%h want 0", sram_addr, sram_wdata); end
        @(negedge clk);
        rst = 1'b0;
        start_mem(1'b0, 16'h0040, 16'h0000);
        run_cycles(4, -1);
        n_vec++; if (h_mr[3:0] !== 4'b0100) begin n_err++; $display("FAIL rstw_idle_load got %b want 0100", h_mr[3:0]); end
        n_vec++; if (d_mem !== 16'hBEEF) begin n_err++; $display("FAIL rstw_idle_data got %h want beef", d_mem); end
    endtask

    initial begin
        bus.if_req_i = 1'b0; bus.if_addr_i = 16'h0000;
        bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = 16'h0000; bus.mem_wdata_i = 16'h0000;
        d_if = 16'h0000; d_mem = 16'h0000; d_wd = 16'h0000; a_rd = 18'h0;
        rst = 1'b1;
        @(posedge clk);
        test_reset_values();
        @(posedge clk); #1;
        rst = 1'b0;
        preload(10'h040, 16'hBEEF);
        preload(10'h010, 16'h0F0F);
        preload(10'h200, 16'h5A5A);
        preload(10'h080, 16'h7777);
        test_single_load();
        test_store();
        test_if_mem_collision();
        test_fetch_repeat();
        test_back_to_back();
        test_withdraw();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
